// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin, burst-locked N_SRC:1 DDR write stream arbiter with registered output (optional ARB_STATS_EN beat counters)
module ddr_wr_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int SRC_W      = 2
) (
`ifdef ARB_STATS_EN
  input  logic                                      stats_clr,
  output logic [N_SRC*32-1:0]                       beat_total,
`endif
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [7:0]                                burst_len,
  input  logic [N_SRC*(DATA_WIDTH+ADDR_WIDTH)-1:0]  s_axis_tdata,
  input  logic [N_SRC-1:0]                          s_axis_tvalid,
  output logic [N_SRC-1:0]                          s_axis_tready,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0]          m_axis_tdata,
  output logic [SRC_W-1:0]                          m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      busy
);
  localparam int W = DATA_WIDTH + ADDR_WIDTH;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d, user_q, user_d, pick, idx, nxt;
  logic [7:0]         beat_cnt_q, beat_cnt_d, len_q, len_d;
  logic               vld_q, vld_d, hit, out_free, locked, accept, rel;
  logic [W-1:0]       data_q, data_d;
  // first valid source at or after rr_ptr, wrapping modulo N_SRC
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = SRC_W'((int'(rr_ptr_q) + k) % N_SRC);
      if (!hit && s_axis_tvalid[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end
  // grant FSM, burst counting and output register next-state
  always_comb begin
    out_free   = !vld_q || m_axis_tready;
    locked     = state_q == LOCK;
    accept     = locked && s_axis_tvalid[grant_q] && out_free;
    rel        = locked && ((accept && beat_cnt_q == len_q - 8'd1) || (out_free && !s_axis_tvalid[grant_q]));
    nxt        = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    if (!locked && hit) begin
      state_d    = LOCK;
      grant_d    = pick;
      len_d      = (burst_len == 8'd0) ? 8'd1 : burst_len;
      beat_cnt_d = '0;
    end
    if (rel) begin
      state_d  = IDLE;
      rr_ptr_d = nxt;
    end else if (accept)
      beat_cnt_d = beat_cnt_q + 8'd1;
    vld_d  = accept ? 1'b1 : (out_free ? 1'b0 : vld_q);
    data_d = accept ? s_axis_tdata[int'(grant_q)*W +: W] : data_q;
    user_d = accept ? grant_q : user_q;
  end
  // state and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
      user_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      user_q     <= user_d;
    end
  end
  assign s_axis_tready = locked ? (N_SRC'(out_free) << grant_q) : '0;
  assign m_axis_tdata  = data_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tvalid = vld_q;
  assign busy          = locked || vld_q;
`ifdef ARB_STATS_EN
  logic [N_SRC*32-1:0] beat_total_q, beat_total_d;
  // per-source accepted-beat counters; clear wins over increment
  always_comb begin
    beat_total_d = beat_total_q;
    for (int i = 0; i < N_SRC; i++)
      if (stats_clr) beat_total_d[i*32 +: 32] = '0;
      else if (accept && grant_q == SRC_W'(i)) beat_total_d[i*32 +: 32] = beat_total_q[i*32 +: 32] + 32'd1;
  end
  // counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) beat_total_q <= '0;
    else beat_total_q <= beat_total_d;
  end
  assign beat_total = beat_total_q;
`endif
endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// tb_ddr_wr_arbiter: scoreboard bench for ddr_wr_arbiter (stats checks when ARB_STATS_EN is defined)
module tb_ddr_wr_arbiter;
  localparam int N = 4, DW = 64, AW = 32, SW = 2, W = DW + AW;
  logic clk = 1'b0, rstn = 1'b0, m_axis_tready = 1'b0, m_axis_tvalid, busy;
  logic [7:0] burst_len = 8'd0;
  logic [N*W-1:0] s_axis_tdata;
  logic [N-1:0] s_axis_tvalid, s_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tuser;
`ifdef ARB_STATS_EN
  logic stats_clr = 1'b0;
  logic [N*32-1:0] beat_total;
`endif
  always #5 clk = ~clk;
  ddr_wr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_W(SW)) dut (
`ifdef ARB_STATS_EN
    .stats_clr(stats_clr), .beat_total(beat_total),
`endif
    .clk(clk), .rstn(rstn), .burst_len(burst_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy));

  typedef struct packed {logic [SW-1:0] src; logic [W-1:0] d;} exp_t;
  exp_t expq[$];
  int ulog[$], clog[$];
  logic [W-1:0] smem [N][32];
  int shead[N], stail[N];
  logic [N-1:0] sen = '0, in_hs = '0;
  int cyc = 0, multi = 0, tests_run = 0, fails = 0, mf;

  always_comb begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]      = sen[i] && shead[i] < stail[i];
      s_axis_tdata[i*W +: W] = smem[i][shead[i][4:0]];
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (in_hs[i]) shead[i]++;
  end

  always @(negedge clk) begin
    cyc++;
    in_hs = s_axis_tvalid & s_axis_tready;
    if (rstn && $countones(s_axis_tready) > 1) multi++;
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      mf = -1;
      for (int k = 0; k < expq.size(); k++) if (mf < 0 && expq[k].src == m_axis_tuser) mf = k;
      tests_run++;
      if (mf < 0) begin
        fails++;
        $display("FAIL beat_unexpected: got src %0d data %h, required no beat", m_axis_tuser, m_axis_tdata);
      end else begin
        if (m_axis_tdata !== expq[mf].d) begin
          fails++;
          $display("FAIL beat_data src %0d: got %h, required %h", m_axis_tuser, m_axis_tdata, expq[mf].d);
        end
        expq.delete(mf);
      end
      ulog.push_back(int'(m_axis_tuser));
      clog.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int s, input int n);
    logic [W-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = {$urandom, $urandom, $urandom};
      smem[s][stail[s][4:0]] = d;
      stail[s]++;
      expq.push_back({SW'(s), d});
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sen = '0;
    m_axis_tready = 1'b0;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      stail[i] = 0;
    end
    expq.delete();
    ulog.delete();
    clog.delete();
    multi = 0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      fails++;
      $display("FAIL %s_drain: %0d beats still pending after 200 cycles, required 0", name, expq.size());
    end
  endtask

  task automatic wait_beats(input string name, input int n);
    int c = 0;
    while (ulog.size() < n && c < 50) begin
      tick();
      c++;
    end
    tests_run++;
    if (ulog.size() < n) begin
      fails++;
      $display("FAIL %s_wait: got %0d beats, required %0d", name, ulog.size(), n);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests_run += 5;
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b, required 0", m_axis_tvalid); end
    if (m_axis_tdata !== '0) begin fails++; $display("FAIL rst_tdata: got %h, required 0", m_axis_tdata); end
    if (m_axis_tuser !== '0) begin fails++; $display("FAIL rst_tuser: got %0d, required 0", m_axis_tuser); end
    if (s_axis_tready !== '0) begin fails++; $display("FAIL rst_tready: got %b, required 0000", s_axis_tready); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
`ifdef ARB_STATS_EN
    tests_run++;
    if (beat_total !== '0) begin fails++; $display("FAIL rst_stats: got %h, required 0", beat_total); end
`endif
    rstn = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || s_axis_tready !== '0) begin
      fails++;
      $display("FAIL idle_quiet: got busy %b tready %b, required 0 0000", busy, s_axis_tready);
    end
  endtask

  task automatic test_burst_split();
    int gap[4] = '{1, 1, 1, 2};
    do_reset();
    burst_len = 8'd4;
    m_axis_tready = 1'b1;
    push(0, 5);
    sen = 4'b0001;
    drain("burst_split");
    tests_run++;
    if (ulog.size() !== 5) begin fails++; $display("FAIL burst_split_count: got %0d, required 5", ulog.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (ulog[k] !== 0) begin fails++; $display("FAIL burst_split_tuser[%0d]: got %0d, required 0", k, ulog[k]); end
      end
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (clog[k+1] - clog[k] !== gap[k]) begin
          fails++;
          $display("FAIL burst_split_gap[%0d]: got %0d cycles, required %0d", k, clog[k+1] - clog[k], gap[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int e[12] = '{0, 0, 2, 2, 0, 0, 2, 2, 0, 0, 2, 2};
    do_reset();
    burst_len = 8'd2;
    m_axis_tready = 1'b1;
    push(0, 6);
    push(2, 6);
    sen = 4'b0101;
    drain("round_robin");
    tests_run += 2;
    if (multi !== 0) begin fails++; $display("FAIL rr_onehot_ready: got %0d cycles with >1 ready, required 0", multi); end
    if (ulog.size() !== 12) begin fails++; $display("FAIL rr_count: got %0d, required 12", ulog.size()); end
    else for (int k = 0; k < 12; k++) begin
      tests_run++;
      if (ulog[k] !== e[k]) begin fails++; $display("FAIL rr_tuser[%0d]: got %0d, required %0d", k, ulog[k], e[k]); end
    end
  endtask

  task automatic test_len_zero();
    int e[4] = '{0, 1, 0, 1};
    do_reset();
    burst_len = 8'd0;
    m_axis_tready = 1'b1;
    push(0, 2);
    push(1, 2);
    sen = 4'b0011;
    drain("len_zero");
    tests_run++;
    if (ulog.size() !== 4) begin fails++; $display("FAIL len_zero_count: got %0d, required 4", ulog.size()); end
    else for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (ulog[k] !== e[k]) begin fails++; $display("FAIL len_zero_tuser[%0d]: got %0d, required %0d", k, ulog[k], e[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] rd;
    logic [SW-1:0] ru;
    do_reset();
    burst_len = 8'd8;
    m_axis_tready = 1'b1;
    push(1, 6);
    sen = 4'b0010;
    wait_beats("stall", 2);
    m_axis_tready = 1'b0;
    @(negedge clk);
    rd = m_axis_tdata;
    ru = m_axis_tuser;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      tests_run += 4;
      if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL stall_tvalid[%0d]: got %b, required 1", k, m_axis_tvalid); end
      if (m_axis_tdata !== rd) begin fails++; $display("FAIL stall_tdata[%0d]: got %h, required %h", k, m_axis_tdata, rd); end
      if (m_axis_tuser !== 2'd1 || ru !== 2'd1) begin fails++; $display("FAIL stall_tuser[%0d]: got %0d, required 1", k, m_axis_tuser); end
      if (s_axis_tready !== '0) begin fails++; $display("FAIL stall_tready[%0d]: got %b, required 0000", k, s_axis_tready); end
    end
    tick();
    m_axis_tready = 1'b1;
    drain("stall");
    tests_run++;
    if (ulog.size() !== 6) begin fails++; $display("FAIL stall_count: got %0d, required 6", ulog.size()); end
  endtask

  task automatic test_source_gap();
    int e[5] = '{1, 1, 3, 3, 3};
    do_reset();
    burst_len = 8'd8;
    m_axis_tready = 1'b1;
    push(1, 2);
    push(3, 3);
    sen = 4'b1010;
    drain("gap");
    tests_run++;
    if (ulog.size() !== 5) begin fails++; $display("FAIL gap_count: got %0d, required 5", ulog.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (ulog[k] !== e[k]) begin fails++; $display("FAIL gap_tuser[%0d]: got %0d, required %0d", k, ulog[k], e[k]); end
      end
      tests_run++;
      if (clog[2] - clog[1] !== 3) begin fails++; $display("FAIL gap_regrant_cycles: got %0d, required 3", clog[2] - clog[1]); end
    end
  endtask

  task automatic test_mid_reset();
    int e[2] = '{0, 2};
    do_reset();
    burst_len = 8'd4;
    m_axis_tready = 1'b1;
    push(0, 4);
    sen = 4'b0001;
    wait_beats("mid_reset", 2);
    tests_run++;
    if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL mid_reset_pre_tvalid: got %b, required 1", m_axis_tvalid); end
    rstn = 1'b0;
    #1;
    tests_run += 3;
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL mid_reset_tvalid: got %b, required 0", m_axis_tvalid); end
    if (s_axis_tready !== '0) begin fails++; $display("FAIL mid_reset_tready: got %b, required 0000", s_axis_tready); end
    if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    do_reset();
    m_axis_tready = 1'b1;
    push(2, 1);
    push(0, 1);
    sen = 4'b0101;
    drain("post_reset");
    tests_run++;
    if (ulog.size() !== 2) begin fails++; $display("FAIL post_reset_count: got %0d, required 2", ulog.size()); end
    else for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (ulog[k] !== e[k]) begin fails++; $display("FAIL post_reset_tuser[%0d]: got %0d, required %0d", k, ulog[k], e[k]); end
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    burst_len = 8'd8;
    m_axis_tready = 1'b1;
    push(0, 7);
    push(1, 3);
    sen = 4'b0011;
    drain("stats");
    tests_run += 3;
    if (beat_total[31:0] !== 32'd7) begin fails++; $display("FAIL stats_src0: got %0d, required 7", beat_total[31:0]); end
    if (beat_total[63:32] !== 32'd3) begin fails++; $display("FAIL stats_src1: got %0d, required 3", beat_total[63:32]); end
    if (beat_total[127:64] !== '0) begin fails++; $display("FAIL stats_src23: got %h, required 0", beat_total[127:64]); end
    push(0, 4);
    stats_clr = 1'b1;
    drain("stats_clr");
    stats_clr = 1'b0;
    tick();
    tests_run++;
    if (beat_total !== '0) begin fails++; $display("FAIL stats_clr: got %h, required 0", beat_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_burst_split();
    test_round_robin();
    test_len_zero();
    test_backpressure();
    test_source_gap();
    test_mid_reset();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
